// File: rtl/vec_pack_if.sv
// Handshake bundle for vec_pack: FWFT upstream read side, downstream write side,
// plus flush request and status. The slave modport is the packer's view.
interface vec_pack_if #(
   parameter int BUS_WIDTH    = 96,
   parameter int VEC_ID_WIDTH = 8
);
   logic [BUS_WIDTH-1:0]    i_Vector;
   logic                    i_Valid;
   logic                    o_Read;
   logic                    i_Flush;
   logic                    i_Full;
   logic [BUS_WIDTH-1:0]    o_Vector;
   logic                    o_Valid;
   logic [VEC_ID_WIDTH-1:0] o_VecCount;
   logic                    o_Busy;

   modport slave (
      input  i_Vector, i_Valid, i_Flush, i_Full,
      output o_Read, o_Vector, o_Valid, o_VecCount, o_Busy
   );

   modport master (
      output i_Vector, i_Valid, i_Flush, i_Full,
      input  o_Read, o_Vector, o_Valid, o_VecCount, o_Busy
   );
endinterface

// File: rtl/vec_pack.sv
// Packs bus-aligned vectors (last beat zero-padded) densely into a continuous
// BUS_WIDTH word stream, LSB-first, with flush of the trailing partial word.
module vec_pack #(
   parameter int BUS_WIDTH    = 96,
   parameter int VECTOR_WIDTH = 128,
   parameter int VEC_ID_WIDTH = 8
) (
   input  logic      clk,
   input  logic      rstn,
   vec_pack_if.slave bus
);
   localparam int BEATS = (VECTOR_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
   localparam int REM   = VECTOR_WIDTH - (BEATS - 1) * BUS_WIDTH;
   localparam int FW    = $clog2(2 * BUS_WIDTH) + 1;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   localparam logic [FW-1:0] W_F       = FW'(BUS_WIDTH);
   localparam logic [FW-1:0] REM_F     = FW'(REM);
   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

   function automatic logic [BUS_WIDTH-1:0] low_mask(input logic [FW-1:0] nbits);
      logic [BUS_WIDTH-1:0] m;
      for (int i = 0; i < BUS_WIDTH; i++) m[i] = (FW'(i) < nbits);
      return m;
   endfunction

   logic [2*BUS_WIDTH-1:0]  acc_q, acc_d, acc_sh;
   logic [FW-1:0]           fill_q, fill_d, fill_sh, nbits;
   logic [BW-1:0]           beat_q, beat_d;
   logic                    flush_q, flush_d;
   logic [VEC_ID_WIDTH-1:0] cnt_q, cnt_d;
   logic [BUS_WIDTH-1:0]    ovec_q, ovec_d, beat_bits;
   logic                    oval_q, oval_d;
   logic                    last_beat, emit, rd, idle_head, drain;

   // Bits of acc at and above fill are always zero, so beats are OR-ed in.
   always_comb begin
      last_beat = (beat_q == LAST_BEAT);
      emit      = (fill_q >= W_F) && !bus.i_Full;
      rd        = rstn && bus.i_Valid && ((fill_q < W_F) || emit);
      idle_head = flush_q && !bus.i_Valid && (beat_q == '0);
      drain     = idle_head && (fill_q != '0) && (fill_q < W_F) && !bus.i_Full;

      acc_sh    = emit ? (acc_q >> BUS_WIDTH) : acc_q;
      fill_sh   = emit ? (fill_q - W_F) : fill_q;
      nbits     = last_beat ? REM_F : W_F;
      beat_bits = bus.i_Vector & low_mask(nbits);

      acc_d   = acc_sh;
      fill_d  = fill_sh;
      beat_d  = beat_q;
      cnt_d   = cnt_q;
      flush_d = flush_q | bus.i_Flush;
      ovec_d  = ovec_q;
      oval_d  = emit || drain;

      if (emit) ovec_d = acc_q[BUS_WIDTH-1:0];

      if (rd) begin
         acc_d  = acc_sh | ({{BUS_WIDTH{1'b0}}, beat_bits} << fill_sh);
         fill_d = fill_sh + nbits;
         if (last_beat) begin
            beat_d = '0;
            cnt_d  = cnt_q + VEC_ID_WIDTH'(1);
         end else begin
            beat_d = beat_q + BW'(1);
         end
      end

      // Drain only between vectors; a mid-vector flush waits for the last beat.
      if (drain) begin
         ovec_d  = acc_q[BUS_WIDTH-1:0] & low_mask(fill_q);
         acc_d   = '0;
         fill_d  = '0;
         flush_d = 1'b0;
      end else if (idle_head && (fill_q == '0)) begin
         flush_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         acc_q   <= '0;
         fill_q  <= '0;
         beat_q  <= '0;
         flush_q <= 1'b0;
         cnt_q   <= '0;
         ovec_q  <= '0;
         oval_q  <= 1'b0;
      end else begin
         acc_q   <= acc_d;
         fill_q  <= fill_d;
         beat_q  <= beat_d;
         flush_q <= flush_d;
         cnt_q   <= cnt_d;
         ovec_q  <= ovec_d;
         oval_q  <= oval_d;
      end
   end

   assign bus.o_Read     = rd;
   assign bus.o_Vector   = ovec_q;
   assign bus.o_Valid    = oval_q;
   assign bus.o_VecCount = cnt_q;
   assign bus.o_Busy     = (fill_q != '0) || flush_q;
endmodule

// File: tb/tb_vec_pack.sv
// Directed bench for vec_pack: 96/128 packer plus a 64/64 pass-through instance,
// table-driven packing/flush cases and hand sequences for multi-cycle corners.
module tb_vec_pack;
   logic clk = 1'b0;
   logic rstn;
   always #5 clk = ~clk;

   vec_pack_if #(.BUS_WIDTH(96), .VEC_ID_WIDTH(8)) A ();
   vec_pack_if #(.BUS_WIDTH(64), .VEC_ID_WIDTH(8)) B ();

   vec_pack #(.BUS_WIDTH(96), .VECTOR_WIDTH(128), .VEC_ID_WIDTH(8)) dut_a (
      .clk(clk), .rstn(rstn), .bus(A.slave));
   vec_pack #(.BUS_WIDTH(64), .VECTOR_WIDTH(64), .VEC_ID_WIDTH(8)) dut_b (
      .clk(clk), .rstn(rstn), .bus(B.slave));

   int cmps = 0;
   int errs = 0;
   int cyc  = 0;
   logic full_prev = 1'b0;
   int valid_while_full = 0;
   int acc_while_full   = 0;
   logic [95:0]  got_a[$];
   logic [63:0]  got_b[$];
   int           got_b_cyc[$];
   logic [127:0] vecs_q[$];
   logic [95:0]  exp_q[$];

   always @(posedge clk) begin
      cyc       <= cyc + 1;
      full_prev <= A.i_Full;
      if (rstn && A.i_Full && A.o_Read) acc_while_full <= acc_while_full + 1;
   end

   always @(negedge clk) begin
      if (rstn && A.o_Valid) begin
         got_a.push_back(A.o_Vector);
         if (full_prev) valid_while_full <= valid_while_full + 1;
      end
      if (rstn && B.o_Valid) begin
         got_b.push_back(B.o_Vector);
         got_b_cyc.push_back(cyc);
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
      cmps++;
      if (act !== req) begin
         errs++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endtask

   function automatic logic [127:0] vg(input int k);
      logic [31:0] a;
      a = 32'(k);
      return {a * 32'h9E37_79B1, ~a, a ^ 32'hDEAD_BEEF, a + 32'h0100_0001};
   endfunction

   // Reference packing: concatenate vectors as a bit stream, cut into 96-bit words.
   function automatic void build_exp(input bit flush);
      bit sb[$];
      exp_q.delete();
      foreach (vecs_q[k]) for (int i = 0; i < 128; i++) sb.push_back(vecs_q[k][i]);
      if (flush) while ((sb.size() % 96) != 0) sb.push_back(1'b0);
      for (int j = 0; j + 96 <= sb.size(); j += 96) begin
         logic [95:0] w;
         for (int i = 0; i < 96; i++) w[i] = sb[j + i];
         exp_q.push_back(w);
      end
   endfunction

   task automatic do_reset();
      rstn = 1'b0;
      A.i_Valid = 1'b0; A.i_Flush = 1'b0; A.i_Full = 1'b0; A.i_Vector = '0;
      B.i_Valid = 1'b0; B.i_Flush = 1'b0; B.i_Full = 1'b0; B.i_Vector = '0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      vecs_q.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic push_a(input logic [95:0] d);
      int t;
      t = 0;
      A.i_Vector = d;
      A.i_Valid  = 1'b1;
      #1;
      while (!A.o_Read && t < 100) begin
         @(negedge clk); #1; t++;
      end
      if (!A.o_Read) chk("a read timeout", 128'd0, 128'd1);
      else @(posedge clk);
      @(negedge clk);
      A.i_Valid = 1'b0;
   endtask

   task automatic push_b(input logic [63:0] d, output int cap);
      int t;
      t = 0;
      cap = -1;
      B.i_Vector = d;
      B.i_Valid  = 1'b1;
      #1;
      while (!B.o_Read && t < 100) begin
         @(negedge clk); #1; t++;
      end
      if (!B.o_Read) chk("b read timeout", 128'd0, 128'd1);
      else @(posedge clk);
      @(negedge clk);
      cap = cyc;
      B.i_Valid = 1'b0;
   endtask

   task automatic send_a(input logic [127:0] v);
      push_a(v[95:0]);
      push_a({64'hFFFF_FFFF_FFFF_FFFF, v[127:96]});
      vecs_q.push_back(v);
   endtask

   task automatic flush_a();
      A.i_Flush = 1'b1;
      @(negedge clk);
      A.i_Flush = 1'b0;
   endtask

   typedef struct packed {
      logic [1:0]        nvec;
      logic              flush;
      logic              busy_pre;
      logic [2:0]        nwords;
      logic [7:0]        cnt;
      logic [2:0][127:0] vec;
      logic [3:0][95:0]  word;
   } case_t;

   initial begin
      case_t tbl[3];
      int base, vwf0, awf0, bad, cap, cap0;
      logic [95:0]  g;
      logic [127:0] v;

      tbl[0] = '0;
      tbl[0].nvec = 2'd3; tbl[0].flush = 1'b0; tbl[0].busy_pre = 1'b0;
      tbl[0].nwords = 3'd4; tbl[0].cnt = 8'd3;
      tbl[0].vec[0] = {32{4'h1}}; tbl[0].vec[1] = {32{4'h2}}; tbl[0].vec[2] = {32{4'h3}};
      tbl[0].word[0] = {24{4'h1}};
      tbl[0].word[1] = 96'h2222222222222222_11111111;
      tbl[0].word[2] = 96'h33333333_2222222222222222;
      tbl[0].word[3] = {24{4'h3}};
      tbl[1] = '0;
      tbl[1].nvec = 2'd1; tbl[1].flush = 1'b1; tbl[1].busy_pre = 1'b1;
      tbl[1].nwords = 3'd2; tbl[1].cnt = 8'd1;
      tbl[1].vec[0] = {32{4'h1}};
      tbl[1].word[0] = {24{4'h1}};
      tbl[1].word[1] = 96'h0000000000000000_11111111;
      tbl[2] = tbl[0];
      tbl[2].flush = 1'b1;

      // Asynchronous reset values, checked before any clock edge.
      rstn = 1'b1;
      A.i_Flush = 1'b0; A.i_Full = 1'b0; A.i_Vector = '0; A.i_Valid = 1'b1;
      B.i_Flush = 1'b0; B.i_Full = 1'b0; B.i_Vector = '0; B.i_Valid = 1'b0;
      #1 rstn = 1'b0;
      #1;
      chk("reset o_Vector",   128'(A.o_Vector),   128'd0);
      chk("reset o_Valid",    128'(A.o_Valid),    128'd0);
      chk("reset o_VecCount", 128'(A.o_VecCount), 128'd0);
      chk("reset o_Busy",     128'(A.o_Busy),     128'd0);
      chk("reset o_Read",     128'(A.o_Read),     128'd0);

      for (int c = 0; c < 3; c++) begin
         do_reset();
         base = got_a.size();
         for (int k = 0; k < int'(tbl[c].nvec); k++) send_a(tbl[c].vec[k]);
         idle(4);
         chk($sformatf("case%0d busy before flush", c), 128'(A.o_Busy), 128'(tbl[c].busy_pre));
         if (tbl[c].flush) flush_a();
         idle(6);
         chk($sformatf("case%0d word count", c), 128'(got_a.size() - base), 128'(tbl[c].nwords));
         for (int w = 0; w < int'(tbl[c].nwords); w++) begin
            g = (base + w < got_a.size()) ? got_a[base + w] : 'x;
            chk($sformatf("case%0d word%0d", c, w), 128'(g), 128'(tbl[c].word[w]));
         end
         chk($sformatf("case%0d vec count", c), 128'(A.o_VecCount), 128'(tbl[c].cnt));
         chk($sformatf("case%0d busy after", c), 128'(A.o_Busy), 128'd0);
      end

      // Flush arriving mid-vector waits for the last beat, then drains.
      do_reset();
      base = got_a.size();
      push_a({24{4'h1}});
      flush_a();
      idle(3);
      chk("midflush words before last beat", 128'(got_a.size() - base), 128'd1);
      chk("midflush busy while pending", 128'(A.o_Busy), 128'd1);
      push_a({64'hFFFF_FFFF_FFFF_FFFF, 32'h11111111});
      idle(5);
      chk("midflush word count", 128'(got_a.size() - base), 128'd2);
      g = (base + 1 < got_a.size()) ? got_a[base + 1] : 'x;
      chk("midflush drained word", 128'(g), 128'(96'h0000000000000000_11111111));
      chk("midflush busy after", 128'(A.o_Busy), 128'd0);

      // Backpressure window in the middle of an 8-vector stream.
      do_reset();
      base = got_a.size();
      vwf0 = valid_while_full;
      awf0 = acc_while_full;
      fork
         begin
            for (int k = 0; k < 8; k++) send_a(vg(k + 20));
         end
         begin
            idle(5);
            A.i_Full = 1'b1;
            idle(5);
            A.i_Full = 1'b0;
         end
      join
      idle(4);
      flush_a();
      idle(6);
      build_exp(1'b1);
      chk("bp word count", 128'(got_a.size() - base), 128'(exp_q.size()));
      for (int w = 0; w < exp_q.size(); w++) begin
         g = (base + w < got_a.size()) ? got_a[base + w] : 'x;
         chk($sformatf("bp word%0d", w), 128'(g), 128'(exp_q[w]));
      end
      chk("bp valid while full", 128'(valid_while_full - vwf0), 128'd0);
      chk("bp beats accepted while full over 2", 128'((acc_while_full - awf0) > 2), 128'd0);

      // 256 vectors: counter wraps, 32 bits remain until flushed.
      do_reset();
      base = got_a.size();
      for (int k = 0; k < 256; k++) send_a(vg(k));
      idle(4);
      build_exp(1'b0);
      chk("wrap vec count", 128'(A.o_VecCount), 128'd0);
      chk("wrap word count", 128'(got_a.size() - base), 128'd341);
      bad = 0;
      for (int w = 0; w < exp_q.size(); w++)
         if (base + w >= got_a.size() || got_a[base + w] !== exp_q[w]) bad++;
      chk("wrap words differing", 128'(bad), 128'd0);
      chk("wrap busy", 128'(A.o_Busy), 128'd1);
      flush_a();
      idle(6);
      chk("wrap flushed word count", 128'(got_a.size() - base), 128'd342);
      v = vg(255);
      g = (base + 341 < got_a.size()) ? got_a[base + 341] : 'x;
      chk("wrap last word", 128'(g), 128'({64'h0, v[127:96]}));

      // Asynchronous reset after 1.5 vectors, then a fresh stream.
      do_reset();
      send_a(vg(1000));
      v = vg(1001);
      push_a(v[95:0]);
      A.i_Vector = v[95:0];
      A.i_Valid  = 1'b1;
      #2 rstn = 1'b0;
      #1;
      chk("midrst o_Vector",   128'(A.o_Vector),   128'd0);
      chk("midrst o_Valid",    128'(A.o_Valid),    128'd0);
      chk("midrst o_VecCount", 128'(A.o_VecCount), 128'd0);
      chk("midrst o_Busy",     128'(A.o_Busy),     128'd0);
      chk("midrst o_Read",     128'(A.o_Read),     128'd0);
      A.i_Valid = 1'b0;
      idle(2);
      rstn = 1'b1;
      vecs_q.delete();
      base = got_a.size();
      send_a(vg(7));
      send_a(vg(8));
      idle(4);
      flush_a();
      idle(6);
      build_exp(1'b1);
      chk("postrst word count", 128'(got_a.size() - base), 128'(exp_q.size()));
      for (int w = 0; w < exp_q.size(); w++) begin
         g = (base + w < got_a.size()) ? got_a[base + w] : 'x;
         chk($sformatf("postrst word%0d", w), 128'(g), 128'(exp_q[w]));
      end

      // 64/64 instance: pass-through at one word per cycle, latency one cycle.
      do_reset();
      base = got_b.size();
      cap0 = -1;
      for (int k = 0; k < 10; k++) begin
         v = vg(k + 500);
         push_b(v[63:0], cap);
         if (k == 0) cap0 = cap;
      end
      idle(4);
      chk("b word count", 128'(got_b.size() - base), 128'd10);
      for (int k = 0; k < 10; k++) begin
         v = vg(k + 500);
         chk($sformatf("b word%0d", k),
             128'((base + k < got_b.size()) ? got_b[base + k] : 64'hx), 128'(v[63:0]));
      end
      chk("b first latency", 128'((base < got_b_cyc.size()) ? got_b_cyc[base] : -1), 128'(cap0 + 1));
      bad = 0;
      for (int k = 1; k < 10; k++)
         if (base + k >= got_b_cyc.size() || got_b_cyc[base + k] != got_b_cyc[base] + k) bad++;
      chk("b non-consecutive words", 128'(bad), 128'd0);
      chk("b vec count", 128'(B.o_VecCount), 128'd10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
      $finish;
   end
endmodule
